ml_acc_conv_seq: RTL and testbench
==================================

# ml_acc_conv_seq

Convolution sequencer for the ML accelerator PL subsystem. It sits between the AXI-lite control register file and the three accelerator BRAMs: input activations, weights and output activations. On a start command it walks every output pixel of a stride-1, unpadded 2-D convolution. For each pixel it reads matching input and weight words in lockstep, accumulates the products and writes the result to the output BRAM. It then reports busy, done and an interrupt pulse back to the register file.

## Interface
Parameters:
- IN_DIM, 7, input feature map side length (square)
- K, 5, kernel side length; requires K <= IN_DIM
- AW, 10, BRAM word-address width

Ports:
- ACLK  in  1  single clock for all logic
- ARESET  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle start pulse, from the reg-10 bit-0 write
- busy_o  out  1  high while a convolution is in progress
- done_o  out  1  sticky completion flag, cleared by an accepted start
- irq_o  out  1  one-cycle pulse on completion
- in_en_o / in_addr_o  out  1 / AW  input BRAM read enable and word address
- in_rdata_i  in  32  input BRAM data, valid 1 cycle after in_en_o
- w_en_o / w_addr_o  out  1 / AW  weight BRAM read enable and word address
- w_rdata_i  in  32  weight BRAM data, valid 1 cycle after w_en_o
- out_en_o / out_we_o  out  1 / 4  output BRAM enable and byte write enables
- out_addr_o / out_wdata_o  out  AW / 32  output word address and data

## Operation
- Derived sizes: OUT_DIM = IN_DIM-K+1; P = OUT_DIM².
- Operands are the signed 16-bit values in bits [15:0] of each read word; bits [31:16] are ignored.
- Products are signed 32-bit. The accumulator is signed 32-bit and wraps modulo 2³²; there is no saturation.
- Addressing, for output (r,c) and tap (kr,kc):
  - in_addr = (r+kr)*IN_DIM + (c+kc)
  - w_addr = kr*K + kc
  - out_addr = r*OUT_DIM + c
- Taps run kc fastest, then kr. Pixels run c fastest, then r.
- FSM states:
  - IDLE: start_i → ISSUE. Clear done_o, the accumulator and r, c, kr, kc.
  - ISSUE: assert in_en_o and w_en_o with the current tap addresses for K*K cycles. Data returned on the next cycle is multiplied and accumulated. After the last tap → TAIL.
  - TAIL: one cycle; the final product is accumulated.
  - WRITE: one cycle. out_en_o=1, out_we_o=4'hF, out_wdata_o = accumulator. Clear the accumulator. If this is the last pixel → DONE, else advance (r,c) → ISSUE.
  - DONE: one cycle. Pulse irq_o, set done_o → IDLE.
- start_i is ignored in every state except IDLE.
- out_we_o is 0 in every cycle except WRITE. in_en_o and w_en_o are 0 in every cycle except ISSUE.

## Timing
- Reset values: busy_o, done_o, irq_o, all enables, out_we_o, all addresses and out_wdata_o are 0. State is IDLE.
- ARESET mid-run: the FSM returns to IDLE the next cycle. No further BRAM accesses or writes occur, and done_o stays 0.
- Cycle numbering, with start_i sampled high in IDLE at edge N:
  - busy_o and the first read enables are high from cycle N+1.
  - Each pixel takes exactly K*K+2 cycles.
  - The last WRITE occurs at N+P*(K*K+2).
  - done_o rises, irq_o pulses and busy_o falls at N+P*(K*K+2)+1.
- start_i coinciding with the DONE cycle is ignored. It is accepted from the following cycle (IDLE).
- ARESET has priority over start_i in the same cycle.

## Configuration
- ML_ACC_SEQ_RELU_EN defined: in WRITE, out_wdata_o = (acc < 0) ? 0 : acc.
- ML_ACC_SEQ_RELU_EN undefined: out_wdata_o = acc, raw two's complement.

## Structure
- Shared package ml_acc_pkg holds:
  - the state enum {IDLE, ISSUE, TAIL, WRITE, DONE}
  - the data width (32) and operand width (16)
  - the derived-size helpers for OUT_DIM and P
- One sub-module, ml_acc_mac: a registered signed 16×16 multiply with a wrapping 32-bit accumulator, clear and enable inputs, and the same ACLK/ARESET.

## Test plan
- IN_DIM=5, K=5; input all 1, weights 1..25; start at N → exactly one write: out_addr 0, data 325 at N+27; done_o and irq_o at N+28.
- IN_DIM=7, K=5; input[i]=i, weights all 1 → 9 writes. Required out[0..8]: 400, 425, 450, 575, 600, 625, 750, 775, 800. Total run 243 cycles.
- Weights all 0xFFFF (−1), input all 3, IN_DIM=K=5 → written data 0 with ML_ACC_SEQ_RELU_EN, 0xFFFFFFB5 without.
- Input and weights all 0x7FFF, IN_DIM=K=5 → wrapped result 0x3FE70019. Also: bits [31:16]=0xDEAD on every word leave the result unchanged.
- start_i pulsed again mid-run and on the DONE cycle (IN_DIM=7) → still exactly 9 writes, a single irq_o pulse, and busy_o timing unchanged.
- ARESET for 1 cycle at N+50 (IN_DIM=7) → busy_o, done_o and every enable are 0 from the next cycle, no out_we_o afterwards. A fresh start then produces the full correct 9-write sequence.

Source files
------------

// File: rtl/ml_acc_pkg.sv
// Shared types and size helpers for the convolution sequencer and its MAC.
package ml_acc_pkg;

  localparam int DATA_W = 32;
  localparam int OPND_W = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, TAIL, WRITE, DONE} state_t;

  // Loop counters; wide enough for feature maps up to 255 pixels per side.
  typedef logic [7:0] idx_t;

  function automatic int out_dim(int in_dim, int k);
    return in_dim - k + 1;
  endfunction

  function automatic int num_pix(int in_dim, int k);
    return out_dim(in_dim, k) * out_dim(in_dim, k);
  endfunction

  function automatic int lin_addr(int row, int col, int dim);
    return row * dim + col;
  endfunction

endpackage

// File: rtl/ml_acc_conv_seq_if.sv
// BRAM-side bundle of the convolution sequencer: input/weight read ports and output write port.
interface ml_acc_conv_seq_if #(
  parameter int AW = 10
);
  import ml_acc_pkg::*;

  logic              in_en_o;
  logic [AW-1:0]     in_addr_o;
  logic [DATA_W-1:0] in_rdata_i;
  logic              w_en_o;
  logic [AW-1:0]     w_addr_o;
  logic [DATA_W-1:0] w_rdata_i;
  logic              out_en_o;
  logic [3:0]        out_we_o;
  logic [AW-1:0]     out_addr_o;
  logic [DATA_W-1:0] out_wdata_o;

  modport master (
    output in_en_o, in_addr_o, w_en_o, w_addr_o,
    output out_en_o, out_we_o, out_addr_o, out_wdata_o,
    input  in_rdata_i, w_rdata_i
  );

  modport slave (
    input  in_en_o, in_addr_o, w_en_o, w_addr_o,
    input  out_en_o, out_we_o, out_addr_o, out_wdata_o,
    output in_rdata_i, w_rdata_i
  );

endinterface

// File: rtl/ml_acc_mac.sv
// Signed 16x16 multiply into a wrapping 32-bit accumulator register; clear wins over enable.
// acc_nxt_o is the value the accumulator takes at the coming edge, so a caller can capture it same-cycle.
module ml_acc_mac
  import ml_acc_pkg::*;
(
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [OPND_W-1:0] a_i,
  input  logic signed [OPND_W-1:0] b_i,
  output logic signed [DATA_W-1:0] acc_nxt_o
);

  logic signed [DATA_W-1:0] prod;
  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] acc_d;

  assign prod = 32'(a_i) * 32'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/ml_acc_conv_seq.sv
// Stride-1 unpadded 2-D convolution sequencer: per output pixel, K*K lockstep reads, MAC, one write.
// Each pixel takes K*K+2 cycles; ML_ACC_SEQ_RELU_EN clamps negative results to zero on write.
module ml_acc_conv_seq
  import ml_acc_pkg::*;
#(
  parameter int IN_DIM = 7,
  parameter int K      = 5,
  parameter int AW     = 10
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               irq_o,
  ml_acc_conv_seq_if.master  bram
);

  localparam int   OUT_DIM = out_dim(IN_DIM, K);
  localparam idx_t KM1     = idx_t'(K - 1);
  localparam idx_t OM1     = idx_t'(OUT_DIM - 1);
  localparam idx_t ONE     = idx_t'(1);

  state_t            state_q;
  idx_t              r_q, c_q, kr_q, kc_q;
  logic              busy_q, done_q, irq_q;
  logic              rd_en_q, rd_vld_q;
  logic [AW-1:0]     in_addr_q, w_addr_q, out_addr_q;
  logic              out_en_q;
  logic [3:0]        out_we_q;
  logic [DATA_W-1:0] out_wdata_q;

  logic              kc_end, c_end, last_tap, last_pix, mac_clr;
  idx_t              kc_inc, kr_inc, c_inc, r_inc;
  logic signed [DATA_W-1:0] acc_nxt;
  logic              unused_hi;

  function automatic logic [DATA_W-1:0] wr_val(input logic signed [DATA_W-1:0] a);
`ifdef ML_ACC_SEQ_RELU_EN
    return a[DATA_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  assign kc_end   = (kc_q == KM1);
  assign kc_inc   = kc_end ? '0 : kc_q + ONE;
  assign kr_inc   = kc_end ? kr_q + ONE : kr_q;
  assign last_tap = kc_end && (kr_q == KM1);
  assign c_end    = (c_q == OM1);
  assign c_inc    = c_end ? '0 : c_q + ONE;
  assign r_inc    = c_end ? r_q + ONE : r_q;
  assign last_pix = c_end && (r_q == OM1);

  // Read data lags the enable by one cycle, so the MAC enable is the delayed read enable.
  assign mac_clr  = (state_q == IDLE) || (state_q == WRITE);

  ml_acc_mac u_mac (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .clr_i     (mac_clr),
    .en_i      (rd_vld_q),
    .a_i       (bram.in_rdata_i[OPND_W-1:0]),
    .b_i       (bram.w_rdata_i[OPND_W-1:0]),
    .acc_nxt_o (acc_nxt)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      out_addr_q  <= '0;
      out_en_q    <= 1'b0;
      out_we_q    <= '0;
      out_wdata_q <= '0;
    end else begin
      irq_q       <= 1'b0;
      out_en_q    <= 1'b0;
      out_we_q    <= '0;
      out_wdata_q <= '0;
      rd_vld_q    <= rd_en_q;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            rd_en_q   <= 1'b1;
            in_addr_q <= '0;
            w_addr_q  <= '0;
          end
        end
        ISSUE: begin
          if (last_tap) begin
            state_q <= TAIL;
            rd_en_q <= 1'b0;
            kr_q    <= '0;
            kc_q    <= '0;
          end else begin
            kr_q      <= kr_inc;
            kc_q      <= kc_inc;
            in_addr_q <= AW'(lin_addr(int'(r_q) + int'(kr_inc), int'(c_q) + int'(kc_inc), IN_DIM));
            w_addr_q  <= AW'(lin_addr(int'(kr_inc), int'(kc_inc), K));
          end
        end
        TAIL: begin
          // acc_nxt already holds the final product of this pixel.
          state_q     <= WRITE;
          out_en_q    <= 1'b1;
          out_we_q    <= 4'hF;
          out_addr_q  <= AW'(lin_addr(int'(r_q), int'(c_q), OUT_DIM));
          out_wdata_q <= wr_val(acc_nxt);
        end
        WRITE: begin
          if (last_pix) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
          end else begin
            state_q   <= ISSUE;
            r_q       <= r_inc;
            c_q       <= c_inc;
            rd_en_q   <= 1'b1;
            in_addr_q <= AW'(lin_addr(int'(r_inc), int'(c_inc), IN_DIM));
            w_addr_q  <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign unused_hi        = ^{bram.in_rdata_i[DATA_W-1:OPND_W], bram.w_rdata_i[DATA_W-1:OPND_W]};

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign irq_o            = irq_q;
  assign bram.in_en_o     = rd_en_q;
  assign bram.in_addr_o   = in_addr_q;
  assign bram.w_en_o      = rd_en_q;
  assign bram.w_addr_o    = w_addr_q;
  assign bram.out_en_o    = out_en_q;
  assign bram.out_we_o    = out_we_q;
  assign bram.out_addr_o  = out_addr_q;
  assign bram.out_wdata_o = out_wdata_q;

endmodule

// File: tb/tb_ml_acc_conv_seq.sv
// Self-checking bench for ml_acc_conv_seq (IN_DIM=7, K=5) against a direct convolution model.
module tb_ml_acc_conv_seq;

  localparam int IN_DIM = 7;
  localparam int K      = 5;
  localparam int AW     = 10;
  localparam int OD     = IN_DIM - K + 1;
  localparam int P      = OD * OD;
  localparam int PIX    = K * K + 2;
  localparam int NIN    = IN_DIM * IN_DIM;
  localparam int NW     = K * K;

  logic ACLK    = 1'b0;
  logic ARESET  = 1'b1;
  logic start_i = 1'b0;
  logic busy_o, done_o, irq_o;

  ml_acc_conv_seq_if #(.AW(AW)) bif ();

  ml_acc_conv_seq #(.IN_DIM(IN_DIM), .K(K), .AW(AW)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .irq_o   (irq_o),
    .bram    (bif)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic [31:0] in_mem [NIN];
  logic [31:0] w_mem  [NW];
  logic [31:0] exp_out [P];
  logic [31:0] tbl0 [P] = '{32'd400, 32'd425, 32'd450, 32'd575, 32'd600,
                            32'd625, 32'd750, 32'd775, 32'd800};

  function automatic logic [31:0] rd_in(input logic [AW-1:0] a);
    int i = int'(a);
    return (i < NIN) ? in_mem[i] : 32'hBAD0BAD0;
  endfunction

  function automatic logic [31:0] rd_w(input logic [AW-1:0] a);
    int i = int'(a);
    return (i < NW) ? w_mem[i] : 32'hBAD0BAD0;
  endfunction

  always @(posedge ACLK) begin
    if (bif.in_en_o) bif.in_rdata_i <= rd_in(bif.in_addr_o);
    if (bif.w_en_o)  bif.w_rdata_i  <= rd_w(bif.w_addr_o);
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event log filled at every falling edge.
  int          wr_n, irq_n, irq_c, busy_rise_n, busy_rise_c, busy_fall_c, done_rise_c;
  int          en_n, last_en, en_mis, we_bad;
  int          wr_a [16];
  logic [31:0] wr_d [16];
  int          wr_c [16];
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;

  task automatic clr_log();
    wr_n = 0; irq_n = 0; irq_c = -1; busy_rise_n = 0; busy_rise_c = -1;
    busy_fall_c = -1; done_rise_c = -1; en_n = 0; last_en = -1; en_mis = 0; we_bad = 0;
  endtask

  always @(negedge ACLK) begin
    if (bif.in_en_o === 1'b1) begin
      en_n++;
      last_en = cyc;
    end
    if (bif.in_en_o !== bif.w_en_o) en_mis++;
    if (bif.out_we_o !== 4'h0) begin
      if (bif.out_we_o !== 4'hF || bif.out_en_o !== 1'b1) we_bad++;
      if (wr_n < 16) begin
        wr_a[wr_n] = int'(bif.out_addr_o);
        wr_d[wr_n] = bif.out_wdata_o;
        wr_c[wr_n] = cyc;
      end
      wr_n++;
    end
    if (irq_o === 1'b1) begin
      irq_n++;
      irq_c = cyc;
    end
    if (busy_o === 1'b1 && !prev_busy) begin
      busy_rise_n++;
      busy_rise_c = cyc;
    end
    if (busy_o === 1'b0 && prev_busy) busy_fall_c = cyc;
    if (done_o === 1'b1 && !prev_done) done_rise_c = cyc;
    prev_busy = (busy_o === 1'b1);
    prev_done = (done_o === 1'b1);
  end

  task automatic fill(input int pat);
    for (int i = 0; i < NIN; i++) begin
      case (pat)
        0:       in_mem[i] = 32'(i);
        2:       in_mem[i] = 32'h0000_7FFF;
        3:       in_mem[i] = 32'd3;
        4:       in_mem[i] = 32'hDEAD_7FFF;
        default: in_mem[i] = $urandom;
      endcase
    end
    for (int i = 0; i < NW; i++) begin
      case (pat)
        0:       w_mem[i] = 32'd1;
        2:       w_mem[i] = 32'h0000_7FFF;
        3:       w_mem[i] = 32'h0000_FFFF;
        4:       w_mem[i] = 32'hDEAD_7FFF;
        default: w_mem[i] = $urandom;
      endcase
    end
  endtask

  // Direct definition of the convolution: signed 16-bit operands, 32-bit wrap.
  task automatic build_ref();
    for (int r = 0; r < OD; r++) begin
      for (int c = 0; c < OD; c++) begin
        int acc = 0;
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            logic [31:0] iv = in_mem[(r + kr) * IN_DIM + c + kc];
            logic [31:0] wv = w_mem[kr * K + kc];
            acc += int'($signed(iv[15:0])) * int'($signed(wv[15:0]));
          end
        end
`ifdef ML_ACC_SEQ_RELU_EN
        if (acc < 0) acc = 0;
`endif
        exp_out[r * OD + c] = 32'(acc);
      end
    end
  endtask

  function automatic logic [31:0] const_exp(input int pat, input int p);
    case (pat)
      0:       return tbl0[p];
      2, 4:    return 32'h3FE7_0019;
`ifdef ML_ACC_SEQ_RELU_EN
      3:       return 32'h0000_0000;
`else
      3:       return 32'hFFFF_FFB5;
`endif
      default: return exp_out[p];
    endcase
  endfunction

  // mode 0: plain run; mode 1: extra start pulses mid-run and on DONE; mode 2: reset at N+50.
  task automatic run_conv(input int pat, input int mode);
    int n0;
    int nw;
    fill(pat);
    build_ref();
    @(posedge ACLK);
    #1;
    clr_log();
    @(negedge ACLK);
    n0 = cyc;
    start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    chk("go_busy", 32'(busy_o), 32'd1);
    chk("go_done_clr", 32'(done_o), 32'd0);
    chk("go_rd_en", 32'(bif.in_en_o), 32'd1);
    chk("go_in_addr", 32'(bif.in_addr_o), 32'd0);
    while (cyc < n0 + P * PIX + 8) begin
      @(negedge ACLK);
      start_i = (mode == 1) && (cyc == n0 + 29 || cyc == n0 + P * PIX + 1);
      ARESET  = (mode == 2) && (cyc == n0 + 49);
      if (mode == 2 && cyc == n0 + 50) begin
        chk("rst_now_busy", 32'(busy_o), 32'd0);
        chk("rst_now_done", 32'(done_o), 32'd0);
        chk("rst_now_en", 32'({bif.in_en_o, bif.w_en_o, bif.out_en_o}), 32'd0);
      end
    end
    start_i = 1'b0;
    ARESET  = 1'b0;
    if (mode == 2) begin
      chk("rst_writes", 32'(wr_n), 32'd1);
      chk("rst_wr0_dat", wr_d[0], exp_out[0]);
      chk("rst_last_en", 32'(last_en), 32'(n0 + 49));
      chk("rst_busy_fall", 32'(busy_fall_c), 32'(n0 + 50));
      chk("rst_irq_n", 32'(irq_n), 32'd0);
      chk("rst_done_rise", 32'(done_rise_c), 32'hFFFF_FFFF);
      chk("rst_done", 32'(done_o), 32'd0);
    end else begin
      chk("n_writes", 32'(wr_n), 32'(P));
      nw = (wr_n < P) ? wr_n : P;
      for (int p = 0; p < nw; p++) begin
        chk($sformatf("p%0d_wr%0d_addr", pat, p), 32'(wr_a[p]), 32'(p));
        chk($sformatf("p%0d_wr%0d_model", pat, p), wr_d[p], exp_out[p]);
        if (pat != 1) chk($sformatf("p%0d_wr%0d_const", pat, p), wr_d[p], const_exp(pat, p));
        chk($sformatf("p%0d_wr%0d_cyc", pat, p), 32'(wr_c[p]), 32'(n0 + (p + 1) * PIX));
      end
      chk("reads", 32'(en_n), 32'(P * K * K));
      chk("irq_n", 32'(irq_n), 32'd1);
      chk("irq_cyc", 32'(irq_c), 32'(n0 + P * PIX + 1));
      chk("busy_rise_n", 32'(busy_rise_n), 32'd1);
      chk("busy_rise", 32'(busy_rise_c), 32'(n0 + 1));
      chk("busy_fall", 32'(busy_fall_c), 32'(n0 + P * PIX + 1));
      chk("done_rise", 32'(done_rise_c), 32'(n0 + P * PIX + 1));
      chk("done_sticky", 32'(done_o), 32'd1);
    end
    chk("en_pair", 32'(en_mis), 32'd0);
    chk("we_shape", 32'(we_bad), 32'd0);
  endtask

  initial begin
    clr_log();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done0", 32'(done_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_en", 32'({bif.in_en_o, bif.w_en_o, bif.out_en_o}), 32'd0);
    chk("rst_we", 32'(bif.out_we_o), 32'd0);
    chk("rst_in_addr", 32'(bif.in_addr_o), 32'd0);
    chk("rst_w_addr", 32'(bif.w_addr_o), 32'd0);
    chk("rst_out_addr", 32'(bif.out_addr_o), 32'd0);
    chk("rst_wdata", bif.out_wdata_o, 32'd0);
    ARESET = 1'b0;
    run_conv(0, 0);
    run_conv(1, 1);
    run_conv(2, 0);
    run_conv(4, 0);
    run_conv(3, 0);
    run_conv(1, 2);
    run_conv(0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
